// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared types and constants for the programmable-modulus counter
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_prescaler.sv
// rtl/mod_counter_prescaler.sv - enable prescaler, one tick per (prescale + 1) enabled cycles
// Present only when MOD_COUNTER_PRESCALE_EN is defined.
`ifdef MOD_COUNTER_PRESCALE_EN
module mod_counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  // >= keeps the phase sane if prescale is lowered below the current count
  assign tick = (cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down counter with runtime modulus, wrap/saturate, tc pulse, sticky ovf
// Optional prescaler enabled by MOD_COUNTER_PRESCALE_EN.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int unsigned RESET_VAL  = 0,
  parameter int          PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      mod_max,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  clr_ovf,
`ifdef MOD_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic                  ovf,
  output logic                  at_max,
  output logic                  at_zero
);

  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] load_q;

`ifdef MOD_COUNTER_PRESCALE_EN
  logic tick;

  mod_counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  assign step = en & tick;
`else
  logic [PRESCALE_W-1:0] unused_prescale_w;
  assign unused_prescale_w = '0;
  assign step = en;
`endif

  assign load_q = (load_val > mod_max) ? mod_max : load_val;

  // Explicit compares only: q + 1 is never taken at q == all-ones, q - 1 never at 0
  always_comb begin
    q_step   = q;
    boundary = 1'b0;
    if (up == DIR_UP) begin
      if (q >= mod_max) begin
        boundary = 1'b1;
        q_step   = (mode == MODE_SAT) ? mod_max : '0;
      end else begin
        q_step = q + 1'b1;
      end
    end else begin
      if (q > mod_max) begin
        q_step = mod_max;
      end else if (q == '0) begin
        boundary = 1'b1;
        q_step   = (mode == MODE_SAT) ? '0 : mod_max;
      end else begin
        q_step = q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= RESET_Q;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (load) begin
        q <= load_q;
      end else if (step) begin
        q <= q_step;
        if (boundary) begin
          tc  <= 1'b1;
          ovf <= 1'b1;
        end
      end
    end
  end

  assign at_max  = (q == mod_max);
  assign at_zero = (q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - self-checking bench for mod_counter (WIDTH=4)
module tb_mod_counter;

  localparam int W  = 4;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         reset, en, up, mode, load, clr_ovf;
  logic [W-1:0] mod_max, load_val;
  logic [W-1:0] q;
  logic         tc, ovf, at_max, at_zero;
`ifdef MOD_COUNTER_PRESCALE_EN
  logic [3:0]   prescale;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mod_counter #(.WIDTH(W), .RESET_VAL(RV), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .mode     (mode),
    .mod_max  (mod_max),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
`ifdef MOD_COUNTER_PRESCALE_EN
    .prescale (prescale),
`endif
    .q        (q),
    .tc       (tc),
    .ovf      (ovf),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  always #5 clk = ~clk;

  // Reference model: integer range arithmetic on the count
  int mq, mps, tgt, hi;
  bit mtc, movf, mvalid, ev, stp;

  always @(posedge clk) begin
    if (reset) begin
      mq = RV; mtc = 0; movf = 0; mps = 0; mvalid = 1;
    end else if (mvalid) begin
      ev = 0;
      hi = int'(mod_max);
      if (load) begin
        mq  = (int'(load_val) > hi) ? hi : int'(load_val);
        mps = 0;
      end else begin
        stp = en;
`ifdef MOD_COUNTER_PRESCALE_EN
        if (en) begin
          mps = mps + 1;
          stp = (mps > int'(prescale));
          if (stp) mps = 0;
        end
`endif
        if (stp) begin
          tgt = up ? mq + 1 : mq - 1;
          if (!up && mq > hi) mq = hi;
          else if (tgt < 0) begin ev = 1; mq = mode ? 0 : hi; end
          else if (tgt > hi) begin ev = 1; mq = mode ? hi : 0; end
          else mq = tgt;
        end
      end
      mtc = ev;
      if (ev) movf = 1;
      else if (clr_ovf) movf = 0;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      n_assert += 5;
      if (int'(q) != mq) begin n_fail++; $display("FAIL model_q: got %0d expected %0d at %0t", q, mq, $time); end
      if (tc != mtc) begin n_fail++; $display("FAIL model_tc: got %0d expected %0d at %0t", tc, mtc, $time); end
      if (ovf != movf) begin n_fail++; $display("FAIL model_ovf: got %0d expected %0d at %0t", ovf, movf, $time); end
      if (at_max != (mq == int'(mod_max))) begin n_fail++; $display("FAIL model_at_max: got %0d at %0t", at_max, $time); end
      if (at_zero != (mq == 0)) begin n_fail++; $display("FAIL model_at_zero: got %0d at %0t", at_zero, $time); end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_assert++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int t2q[4]  = '{8, 9, 9, 9};
  int t2tc[4] = '{0, 0, 1, 1};

  initial begin
    reset = 1; en = 0; up = 1; mode = 0; load = 0; clr_ovf = 0;
    mod_max = 15; load_val = 0;
`ifdef MOD_COUNTER_PRESCALE_EN
    prescale = 0;
`endif
    adv(); adv();
    check("reset_q", q, RV);
    check("reset_tc", tc, 0);
    check("reset_ovf", ovf, 0);
    check("reset_at_zero", at_zero, 1);

    // full-range wrap count up
    reset = 0; en = 1;
    for (int i = 1; i <= 17; i++) begin
      adv();
      check("wrap_up_q", q, i % 16);
      check("wrap_up_tc", tc, (i == 16) ? 1 : 0);
    end
    check("wrap_up_ovf", ovf, 1);

    // saturate up from a load of 7, mod_max 9
    en = 0; mod_max = 9; mode = 1; load = 1; load_val = 7; clr_ovf = 1;
    adv();
    load = 0; clr_ovf = 0;
    check("sat_load_q", q, 7);
    check("sat_load_ovf", ovf, 0);
    en = 1;
    for (int i = 0; i < 4; i++) begin
      adv();
      check("sat_up_q", q, t2q[i]);
      check("sat_up_tc", tc, t2tc[i]);
    end
    check("sat_at_max", at_max, 1);
    check("sat_ovf", ovf, 1);

    // wrap down through zero, mod_max 5
    en = 0; mod_max = 5; mode = 0; load = 1; load_val = 1;
    adv();
    load = 0; en = 1; up = 0;
    adv(); check("down_q0", q, 0); check("down_tc0", tc, 0);
    adv(); check("down_q5", q, 5); check("down_tc5", tc, 1);
    adv(); check("down_q4", q, 4); check("down_tc4", tc, 0);

    // load clamp, then mod_max lowered below q
    en = 0; load = 1; load_val = 12; mod_max = 9;
    adv();
    load = 0;
    check("clamp_q", q, 9);
    mod_max = 3; en = 1; up = 0;
    adv(); check("lower_q", q, 3); check("lower_tc", tc, 0);
    up = 1;
    adv(); check("lower_up_q", q, 0); check("lower_up_tc", tc, 1);

    // clr_ovf against a boundary event
    en = 0; clr_ovf = 1;
    adv(); check("clr_ovf", ovf, 0);
    clr_ovf = 0; load = 1; load_val = 3;
    adv();
    load = 0; en = 1; up = 1; clr_ovf = 1;
    adv(); check("set_wins_ovf", ovf, 1); check("set_wins_q", q, 0);
    en = 0;
    adv(); check("clr_alone_ovf", ovf, 0);
    clr_ovf = 0;

    // reset beats load mid-count
    en = 1; mod_max = 15;
    adv(); adv();
    load = 1; load_val = 3; reset = 1;
    adv();
    check("reset_load_q", q, RV);
    check("reset_load_tc", tc, 0);
    reset = 0; load = 0;

    // mod_max = 0: every step is a boundary event
    mod_max = 0; en = 1; up = 1; mode = 0;
    adv(); check("mm0_up_q", q, 0); check("mm0_up_tc", tc, 1);
    adv(); check("mm0_up_tc2", tc, 1);
    up = 0;
    adv(); check("mm0_dn_tc", tc, 1);
    mode = 1;
    adv(); check("mm0_sat_q", q, 0);
    mod_max = 5;
    adv(); check("sat_dn0_q", q, 0); check("sat_dn0_tc", tc, 1);

`ifdef MOD_COUNTER_PRESCALE_EN
    reset = 1; en = 0; prescale = 2; mod_max = 15; mode = 0; up = 1;
    adv();
    reset = 0; en = 1;
    for (int i = 0; i < 9; i++) adv();
    check("ps_q3", q, 3);
    adv(); adv();
    en = 0;
    adv(); adv(); adv();
    check("ps_freeze_q", q, 3);
    en = 1;
    adv();
    check("ps_resume_q", q, 4);
`endif

    // broad sweep against the model
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 60) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      mode     = $urandom_range(0, 1);
      load     = ($urandom_range(0, 9) == 0);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mod_max = W'($urandom_range(0, 15));
`ifdef MOD_COUNTER_PRESCALE_EN
      if ($urandom_range(0, 30) == 0) prescale = 4'($urandom_range(0, 3));
`endif
      adv();
    end

    reset = 0; en = 0; load = 0; clr_ovf = 0;
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
